// File: rtl/ram_copy_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_arbiter_pkg
// Description : Shared widths and copy-engine state encoding for the
//               RAM port arbiter / block-copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_copy_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 12;
  localparam int DEF_LEN_WIDTH     = 13;
  localparam int DEF_MAX_WAIT      = 8;

  // Copy engine states: idle, read source word, write destination word,
  // one-cycle completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } copy_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_mux
// Description : Per-cycle RAM port arbitration between the CPU (fixed
//               priority) and the copy engine, with a starvation counter
//               that forces one copy grant after MAX_WAIT denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_mux
  import ram_copy_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en_i,
  input  logic                     cpu_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_data_i,
  input  logic                     copy_req_i,
  input  logic                     copy_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] copy_addr_i,
  input  logic [DATA_WIDTH-1:0]    copy_data_i,
  output logic                     cpu_gnt_o,
  output logic                     copy_gnt_o,
  output logic                     cpu_stall_o,
  output logic                     ram_wen_o,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_data_o
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                     force_copy;

  // Grant decision, starvation counter next value and RAM port steering.
  always_comb begin
    force_copy  = copy_req_i && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    cpu_gnt_o   = cpu_en_i & ~force_copy;
    copy_gnt_o  = copy_req_i & (~cpu_en_i | force_copy);
    cpu_stall_o = ~reset & cpu_en_i & force_copy;

    // Counter only runs while the copy engine is asking and losing.
    wait_cnt_d = '0;
    if (copy_req_i && !copy_gnt_o) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    // Idle port keeps the previous address so the RAM sees no spurious change.
    ram_wen_o   = 1'b0;
    ram_addr_o  = last_addr_q;
    ram_data_o  = cpu_data_i;
    last_addr_d = last_addr_q;
    if (copy_gnt_o) begin
      ram_wen_o   = copy_wen_i;
      ram_addr_o  = copy_addr_i;
      ram_data_o  = copy_data_i;
      last_addr_d = copy_addr_i;
    end else if (cpu_gnt_o) begin
      ram_wen_o   = cpu_wen_i;
      ram_addr_o  = cpu_addr_i;
      last_addr_d = cpu_addr_i;
    end
    if (reset) begin
      ram_wen_o = 1'b0;
    end
  end

  // Starvation counter and held address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      last_addr_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_copy_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_arbiter
// Description : Shares a single-port RAM (1-cycle read latency) between the
//               CPU data port and a word-by-word block-copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_copy_arbiter
  import ram_copy_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     cpu_wEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic                     cpu_stall,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_dataOut,
  input  logic                     copy_start,
  input  logic [ADDRESS_WIDTH-1:0] copy_src,
  input  logic [ADDRESS_WIDTH-1:0] copy_dst,
  input  logic [LEN_WIDTH-1:0]     copy_len,
  output logic                     copy_busy,
  output logic                     copy_done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  copy_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d, idx_q, idx_d;
  logic [LEN_WIDTH-1:0]     idx_inc;
  logic                     rd_fresh_q;
  logic [DATA_WIDTH-1:0]    buf_q;
  logic                     cpu_rvalid_q;

  logic                     copy_req, copy_wen, copy_gnt, cpu_gnt;
  logic [ADDRESS_WIDTH-1:0] copy_addr;
  logic [DATA_WIDTH-1:0]    copy_wdata;

  assign copy_req  = (state_q == ST_RD) || (state_q == ST_WR);
  assign copy_wen  = (state_q == ST_WR);
  assign idx_inc   = idx_q + LEN_WIDTH'(1);
  // Addresses wrap naturally by truncating to the RAM address width.
  assign copy_addr = copy_wen ? (dst_q + ADDRESS_WIDTH'(idx_q))
                              : (src_q + ADDRESS_WIDTH'(idx_q));
  // Straight after the read the word is still on the RAM output; later
  // (if the CPU stole that cycle) it comes from the capture buffer.
  assign copy_wdata = rd_fresh_q ? ram_dataOut : buf_q;

  assign copy_busy   = copy_req;
  assign copy_done   = (state_q == ST_DONE);
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_dataOut = ram_dataOut;

  ram_port_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MAX_WAIT     (MAX_WAIT)
  ) u_mux (
    .clk        (clk),
    .reset      (reset),
    .cpu_en_i   (cpu_en),
    .cpu_wen_i  (cpu_wEn),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_dataIn),
    .copy_req_i (copy_req),
    .copy_wen_i (copy_wen),
    .copy_addr_i(copy_addr),
    .copy_data_i(copy_wdata),
    .cpu_gnt_o  (cpu_gnt),
    .copy_gnt_o (copy_gnt),
    .cpu_stall_o(cpu_stall),
    .ram_wen_o  (ram_wEn),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_dataIn)
  );

  // Copy engine next-state and parameter latching.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (copy_start) begin
          if (copy_len != '0) begin
            src_d   = copy_src;
            dst_d   = copy_dst;
            len_d   = copy_len;
            idx_d   = '0;
            state_d = ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (copy_gnt) state_d = ST_WR;
      end
      ST_WR: begin
        if (copy_gnt) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Copy engine state and latched parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  // Read-freshness flag, CPU read response flag and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_fresh_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      rd_fresh_q   <= (state_q == ST_RD) && copy_gnt;
      cpu_rvalid_q <= cpu_en && !cpu_wEn && cpu_gnt;
    end
    if (rd_fresh_q) begin
      buf_q <= ram_dataOut;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_copy_arbiter
// Description : Directed scoreboard bench for ram_copy_arbiter with a
//               behavioural single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_copy_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_en, cpu_wEn;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dataIn;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_dataOut;
  logic          copy_start;
  logic [AW-1:0] copy_src, copy_dst;
  logic [LW-1:0] copy_len;
  logic          copy_busy, copy_done;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn, ram_dataOut;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] mem [0:4095];
  logic          init_mem;

  int lat, stalls;
  bit offpat, wen_seen, busy_seen, fin;

  always #5 clk = ~clk;

  ram_copy_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW), .MAX_WAIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_dataOut(cpu_dataOut),
    .copy_start(copy_start), .copy_src(copy_src), .copy_dst(copy_dst), .copy_len(copy_len),
    .copy_busy(copy_busy), .copy_done(copy_done),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // Single-port RAM: write, else read with one cycle latency.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 4096; a++) mem[a] <= pat(a[AW-1:0]);
    end else if (ram_wEn) begin
      mem[ram_addr] <= ram_dataIn;
    end else begin
      ram_dataOut <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every CPU read response is matched against the queue.
  always @(negedge clk) begin
    #2;
    if (cpu_rvalid) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
      else check("cpu_rdata", cpu_dataOut, exp_q.pop_front());
    end
  end

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    cpu_en = 1'b1; cpu_wEn = 1'b0; cpu_addr = a;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (!cpu_stall) begin
        exp_q.push_back(e);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("cpu_read_timeout", 1, 0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_en = 1'b1; cpu_wEn = 1'b1; cpu_addr = a; cpu_dataIn = d;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (!cpu_stall) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("cpu_write_timeout", 1, 0);
  endtask

  // Returns at the negedge following the start edge.
  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    copy_src = s; copy_dst = d; copy_len = l; copy_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    copy_start = 1'b0;
  endtask

  // lat = index of the edge (counting the start edge as 0) that samples done.
  task automatic wait_done(output int l, output int st, output bit off,
                           output bit wseen, output bit bseen);
    l = -1; st = 0; off = 1'b0; wseen = 1'b0; bseen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (cpu_stall) begin
        st++;
        if (k % 9 != 8) off = 1'b1;
      end
      if (ram_wEn) wseen = 1'b1;
      if (copy_busy) bseen = 1'b1;
      if (copy_done) begin
        l = k + 1;
        @(negedge clk);
        #1;
        check("done_one_cycle", copy_done, 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    cpu_en = 1'b1; cpu_wEn = 1'b1; cpu_addr = 12'h005; cpu_dataIn = '1;
    copy_start = 1'b0; copy_src = '0; copy_dst = '0; copy_len = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_wEn", ram_wEn, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_busy", copy_busy, 0);
    check("rst_done", copy_done, 0);
    check("rst_rvalid", cpu_rvalid, 0);
    @(negedge clk);
    init_mem = 1'b0; reset = 1'b0; cpu_en = 1'b0; cpu_wEn = 1'b0;
    @(negedge clk);

    // Plain CPU write then read back
    cpu_write(12'h310, 32'hDEAD_BEEF);
    cpu_read(12'h310, 32'hDEAD_BEEF);
    cpu_read(12'h311, pat(12'h311));
    cpu_en = 1'b0;
    @(negedge clk);

    // Uncontended len=4 copy
    start_copy(12'h010, 12'h100, 13'd4);
    wait_done(lat, stalls, offpat, wen_seen, busy_seen);
    check("t1_latency", lat, 9);
    check("t1_stalls", stalls, 0);
    check("t1_busy", busy_seen, 1);
    for (int i = 0; i < 4; i++)
      check("t1_dst", mem[12'h100 + i], pat(12'h010 + i[AW-1:0]));
    @(negedge clk);

    // Zero-length copy
    start_copy(12'h010, 12'h200, 13'd0);
    wait_done(lat, stalls, offpat, wen_seen, busy_seen);
    check("t2_latency", lat, 1);
    check("t2_wen", wen_seen, 0);
    check("t2_busy", busy_seen, 0);
    check("t2_dst_untouched", mem[12'h200], pat(12'h200));
    @(negedge clk);

    // Continuous CPU reads during a len=2 copy: starvation guard
    fin = 1'b0;
    fork
      begin
        start_copy(12'h020, 12'h120, 13'd2);
        wait_done(lat, stalls, offpat, wen_seen, busy_seen);
        fin = 1'b1;
      end
      begin
        for (int i = 0; i < 100 && !fin; i++)
          cpu_read(12'h300 + 12'(i % 16), pat(12'h300 + 12'(i % 16)));
        cpu_en = 1'b0;
      end
    join
    check("t3_latency", lat, 37);
    check("t3_stalls", stalls, 4);
    check("t3_stall_period", offpat, 0);
    check("t3_dst0", mem[12'h120], pat(12'h020));
    check("t3_dst1", mem[12'h121], pat(12'h021));
    repeat (2) @(negedge clk);

    // CPU steals the cycle after the copy read
    fork
      begin
        start_copy(12'h030, 12'h130, 13'd1);
        wait_done(lat, stalls, offpat, wen_seen, busy_seen);
      end
      begin
        @(posedge clk); @(negedge clk); @(negedge clk);
        cpu_read(12'h301, pat(12'h301));
        cpu_en = 1'b0;
      end
    join
    check("t4_latency", lat, 4);
    check("t4_dst_from_buf", mem[12'h130], pat(12'h030));
    repeat (2) @(negedge clk);

    // Same-cycle CPU write and copy read of the same address
    fork
      begin
        start_copy(12'h050, 12'h150, 13'd1);
        wait_done(lat, stalls, offpat, wen_seen, busy_seen);
      end
      begin
        @(posedge clk); @(negedge clk);
        cpu_write(12'h050, 32'h1234_5678);
        cpu_en = 1'b0; cpu_wEn = 1'b0;
      end
    join
    check("t5_latency", lat, 4);
    check("t5_dst_new_value", mem[12'h150], 32'h1234_5678);
    @(negedge clk);

    // Wrap-around copy with an ignored start while busy
    fork
      begin
        start_copy(12'hFFE, 12'h7FE, 13'd4);
        wait_done(lat, stalls, offpat, wen_seen, busy_seen);
      end
      begin
        @(posedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        copy_src = 12'h600; copy_dst = 12'h500; copy_len = 13'd1; copy_start = 1'b1;
        @(negedge clk);
        copy_start = 1'b0;
      end
    join
    check("t6_latency", lat, 9);
    check("t6_dst0", mem[12'h7FE], pat(12'hFFE));
    check("t6_dst1", mem[12'h7FF], pat(12'hFFF));
    check("t6_dst2", mem[12'h800], pat(12'h000));
    check("t6_dst3", mem[12'h801], pat(12'h001));
    check("t6_ignored_start", mem[12'h500], pat(12'h500));
    @(negedge clk);
    #1;
    check("t6_idle_after", copy_busy, 0);
    @(negedge clk);

    // Reset in the middle of a copy, then a clean restart
    start_copy(12'h040, 12'h140, 13'd4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_wen_in_reset", ram_wEn, 0);
    @(negedge clk);
    #1;
    check("t7_busy_after_rst", copy_busy, 0);
    check("t7_done_after_rst", copy_done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("t7_no_done", copy_done, 0);
    check("t7_partial_dst0", mem[12'h140], pat(12'h040));
    check("t7_partial_dst1", mem[12'h141], pat(12'h141));
    @(negedge clk);
    start_copy(12'h040, 12'h140, 13'd4);
    wait_done(lat, stalls, offpat, wen_seen, busy_seen);
    check("t7_restart_latency", lat, 9);
    for (int i = 0; i < 4; i++)
      check("t7_restart_dst", mem[12'h140 + i], pat(12'h040 + i[AW-1:0]));

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
